vga_plot_arbiter: RTL and testbench
===================================

# vga_plot_arbiter

Sequencer and arbiter for the 160x120 VGA adapter plot port. On `start` it first clears the whole frame to a fixed colour. It then shares the single `vga_x`/`vga_y`/`vga_colour`/`vga_plot` port between `N_REQ` drawing engines (circle, line, fill) using round-robin arbitration with a per-pixel valid/ready handshake. It sits between the drawing engines and the adapter instance in each task top level.

## Interface
- `N_REQ`, 2: number of drawing requesters (2..4)
- `CLEAR_COLOUR`, 3'b000: colour written during the clear sweep
- `clk`  in  1: system clock (CLOCK_50 at top level)
- `rst_n`  in  1: asynchronous, active-low reset (KEY[3] at top level)
- `start`  in  1: single-cycle pulse; begins clear then arbitration; honoured only in IDLE or DONE
- `req_valid`  in  N_REQ: requester i presents a pixel
- `req_x`  in  N_REQ x 8: pixel x
- `req_y`  in  N_REQ x 7: pixel y
- `req_colour`  in  N_REQ x 3: pixel colour
- `req_last`  in  N_REQ: qualifies the pixel as requester i's final pixel
- `req_ready`  out  N_REQ: one-hot grant; pixel accepted when valid & ready
- `vga_x`  out  8; `vga_y`  out  7; `vga_colour`  out  3; `vga_plot`  out  1: registered adapter port
- `busy`  out  1: high in CLEAR and ARB
- `done`  out  1: high in DONE

## Operation
- States: IDLE, CLEAR, ARB, DONE. Reset enters IDLE.
- IDLE --start--> CLEAR. DONE --start--> CLEAR. In CLEAR and ARB, `start` is ignored.
- CLEAR: the block plots one pixel per cycle with colour CLEAR_COLOUR.
  - Order is x outer (0..159), y inner (0..119): 19200 plots.
  - After plot (159,119) the state goes to ARB. `req_ready` is all zeros throughout CLEAR.
- ARB: the round-robin grant goes to the first requester with `req_valid` high, searching from `ptr`.
  - Requesters whose finished flag is set are skipped.
  - `req_ready` is combinational: the one-hot grant, gated by state == ARB. Zero when no requester is valid.
  - On accept of requester g: `ptr <= (g+1) mod N_REQ`.
  - If `req_last` is also high on that accept, `fin[g] <= 1`.
- Clipping: an accepted pixel with x > 159 or y > 119 is consumed normally, but `vga_plot` stays 0 for it.
- ARB -> DONE in the cycle after the accept that makes `fin` all ones.
- Entering CLEAR clears `fin` and resets `ptr` to 0.
- Fairness: a continuously valid, unfinished requester waits at most N_REQ-1 accepts.

## Timing
- Reset values: `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0, `busy`=0, `done`=0, `req_ready`=0, `ptr`=0, `fin`=0.
- Reset is asynchronous. Asserting it mid-CLEAR or mid-ARB returns the block to IDLE immediately, with `vga_plot` forced low.
- Latency: a handshake at edge t drives `vga_*` from edge t with `vga_plot`=1 for exactly one cycle. Throughput is one pixel per cycle.
- Start timing:
  - `start` sampled at edge t enters CLEAR.
  - The first clear plot (0,0) is visible after edge t+1.
  - The last clear plot is visible after edge t+19200.
  - `req_ready` may assert in the cycle after that.
- `busy` rises with CLEAR entry and falls with DONE entry. `done` holds until the next `start`.
- Requesters must hold x/y/colour/last stable while valid and not ready. The block samples them only on the accept edge.

## Structure
- Shared package `vga_pkg` contains:
  - `X_MAX`=159, `Y_MAX`=119
  - typedefs `xcoord_t` (logic [7:0]), `ycoord_t` (logic [6:0]), `colour_t` (logic [2:0])
  - enum `plot_state_t` {IDLE, CLEAR, ARB, DONE}
- Sub-module `rr_arbiter`: purely combinational rotate-priority grant. Inputs: request vector, mask (`~fin`), `ptr`. Output: one-hot grant.
- Top level `vga_plot_arbiter` holds the FSM, clear counters, `ptr`/`fin` registers and output registers.

## Test plan
- Reset then `start` pulse: exactly 19200 cycles with `vga_plot`=1 and colour 000; first (0,0), last (159,119); `req_ready`=0 throughout; then `busy`=1, state ARB.
- N_REQ=2, only req0 valid, pixels (10,20,3'b100), (11,20), (12,20 last): three plots on consecutive cycles; `done` does not rise because req1 is not finished.
- Both valid continuously, 4 pixels each, last on the 4th: accept order 0,1,0,1,0,1,0,1; `done`=1 one cycle after the 8th accept; `busy`=0.
- req0 pixel (160,5) then (5,120): both get `req_ready`=1; `vga_plot` stays 0; the next in-range pixel (5,5) plots.
- `rst_n` low at clear pixel ~5000: all outputs 0 immediately; after a new `start`, the clear restarts at (0,0).
- `start` pulse during ARB: ignored, `fin`/`ptr` unchanged. `start` in DONE: `done` drops and CLEAR restarts.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and frame limits for the 160x120 VGA adapter plot path.
package vga_pkg;

    localparam logic [7:0] X_MAX = 8'd159;
    localparam logic [6:0] Y_MAX = 7'd119;

    typedef logic [7:0] xcoord_t;
    typedef logic [6:0] ycoord_t;
    typedef logic [2:0] colour_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ARB   = 2'd2,
        DONE  = 2'd3
    } plot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first eligible requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0] elig;

    assign elig = req & mask;

    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Clears the frame on start, then round-robin shares the VGA plot port between drawing engines.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter colour_t     CLEAR_COLOUR = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0][7:0] req_x,
    input  logic [N_REQ-1:0][6:0] req_y,
    input  logic [N_REQ-1:0][2:0] req_colour,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic [7:0]            vga_x,
    output logic [6:0]            vga_y,
    output logic [2:0]            vga_colour,
    output logic                  vga_plot,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    plot_state_t      state;
    xcoord_t          clr_x;
    ycoord_t          clr_y;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] gnt_idx;
    logic [N_REQ-1:0] fin;
    logic [N_REQ-1:0] fin_next;
    logic [N_REQ-1:0] grant;
    logic             accept;
    xcoord_t          acc_x;
    ycoord_t          acc_y;
    colour_t          acc_colour;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .mask  (~fin),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        req_ready  = (state == ARB) ? grant : '0;
        accept     = |req_ready;
        gnt_idx    = '0;
        acc_x      = '0;
        acc_y      = '0;
        acc_colour = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx    = PTR_W'(i);
                acc_x      = req_x[i];
                acc_y      = req_y[i];
                acc_colour = req_colour[i];
            end
        end
        fin_next = fin | (req_ready & req_last);
        ptr_next = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign busy = (state == CLEAR) || (state == ARB);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_x      <= '0;
            clr_y      <= '0;
            ptr        <= '0;
            fin        <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= CLEAR;
                        clr_x <= '0;
                        clr_y <= '0;
                        ptr   <= '0;
                        fin   <= '0;
                    end
                end
                CLEAR: begin
                    vga_x      <= clr_x;
                    vga_y      <= clr_y;
                    vga_colour <= CLEAR_COLOUR;
                    vga_plot   <= 1'b1;
                    // y is the inner loop; the last column hands over to arbitration
                    if (clr_y == Y_MAX) begin
                        clr_y <= '0;
                        if (clr_x == X_MAX) begin
                            clr_x <= '0;
                            state <= ARB;
                        end else begin
                            clr_x <= clr_x + 1'b1;
                        end
                    end else begin
                        clr_y <= clr_y + 1'b1;
                    end
                end
                ARB: begin
                    if (accept) begin
                        vga_x      <= acc_x;
                        vga_y      <= acc_y;
                        vga_colour <= acc_colour;
                        // off-screen pixels are consumed but never plotted
                        vga_plot   <= (acc_x <= X_MAX) && (acc_y <= Y_MAX);
                        ptr        <= ptr_next;
                        fin        <= fin_next;
                        if (&fin_next) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed/randomized bench for vga_plot_arbiter with a behavioural round-robin reference model.
module tb_vga_plot_arbiter;

    localparam int N = 2;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       last;
    } pix_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [N-1:0]      req_valid;
    logic [N-1:0][7:0] req_x;
    logic [N-1:0][6:0] req_y;
    logic [N-1:0][2:0] req_colour;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    pix_t q [N][$];
    int   order[$];
    int   m_ptr;
    bit   m_fin [N];

    always #5 clk = ~clk;

    vga_plot_arbiter #(
        .N_REQ        (N),
        .CLEAR_COLOUR (3'b000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic pix_t mk(input int x, input int y, input int c, input bit last);
        pix_t p;
        p.x    = 8'(x);
        p.y    = 7'(y);
        p.c    = 3'(c);
        p.last = last;
        return p;
    endfunction

    function automatic pix_t rnd_pix(input bit last);
        return mk($urandom_range(175, 0), $urandom_range(127, 0), $urandom_range(7, 0), last);
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += q[i].size();
        return s;
    endfunction

    function automatic bit all_fin();
        for (int i = 0; i < N; i++) if (!m_fin[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic reset_model();
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_fin[i] = 1'b0;
    endtask

    task automatic chk_zero(input string pre);
        chk({pre, "_plot"}, vga_plot, 0);
        chk({pre, "_x"}, vga_x, 0);
        chk({pre, "_y"}, vga_y, 0);
        chk({pre, "_colour"}, vga_colour, 0);
        chk({pre, "_busy"}, busy, 0);
        chk({pre, "_done"}, done, 0);
        chk({pre, "_ready"}, req_ready, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge after the edge that sampled start.
    task automatic check_clear(input int abort_at);
        int bad  = 0;
        int badr = 0;
        for (int k = 0; k < 19200; k++) begin
            @(negedge clk);
            if (!(vga_plot === 1'b1 && vga_x === 8'(k / 120) && vga_y === 7'(k % 120) &&
                  vga_colour === 3'b000))
                bad++;
            if (busy !== 1'b1 || done !== 1'b0) badr++;
            if (k == 0) begin
                chk("clear_first_x", vga_x, 0);
                chk("clear_first_y", vga_y, 0);
            end
            if (k == 19199) begin
                chk("clear_last_x", vga_x, 159);
                chk("clear_last_y", vga_y, 119);
                req_valid = '0;
            end else begin
                req_valid = N'($urandom);
                #1;
                if (req_ready !== '0) badr++;
            end
            if (k == abort_at) begin
                chk("abort_pixels_bad", bad, 0);
                chk("abort_ready_busy_bad", badr, 0);
                #1;
                rst_n = 1'b0;
                #1;
                chk_zero("mid_clear_reset");
                reset_model();
                @(negedge clk);
                req_valid = '0;
                rst_n     = 1'b1;
                return;
            end
        end
        chk("clear_pixels_bad", bad, 0);
        chk("clear_ready_busy_bad", badr, 0);
    endtask

    // Drains the requester queues one negedge-to-negedge cycle at a time.
    task automatic run_arb(input int pvalid, input bit stray0, input int start_at, input int budget);
        bit   vh [N];
        int   cyc = 0;
        int   g;
        pix_t p;
        logic [N-1:0] v;
        logic [N-1:0] exp_ready;
        for (int i = 0; i < N; i++) vh[i] = 1'b0;
        while (pending() > 0 && cyc < budget) begin
            for (int i = 0; i < N; i++) begin
                if (!vh[i] && q[i].size() > 0 && $urandom_range(99, 0) < pvalid) vh[i] = 1'b1;
                v[i] = vh[i] || (stray0 && i == 0);
                if (vh[i]) begin
                    req_x[i]      = q[i][0].x;
                    req_y[i]      = q[i][0].y;
                    req_colour[i] = q[i][0].c;
                    req_last[i]   = q[i][0].last;
                end else if (stray0 && i == 0) begin
                    req_x[i]      = 8'd1;
                    req_y[i]      = 7'd1;
                    req_colour[i] = 3'd7;
                    req_last[i]   = 1'b1;
                end else begin
                    req_x[i]      = 8'($urandom);
                    req_y[i]      = 7'($urandom);
                    req_colour[i] = 3'($urandom);
                    req_last[i]   = 1'($urandom);
                end
            end
            req_valid = v;
            start     = (cyc == start_at);
            #1;
            g = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && v[i] && !m_fin[i]) g = i;
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            if (g >= 0) begin
                p     = q[g].pop_front();
                vh[g] = 1'b0;
                m_ptr = (g + 1) % N;
                if (p.last) m_fin[g] = 1'b1;
                order.push_back(g);
            end
            @(negedge clk);
            start = 1'b0;
            chk("vga_plot", vga_plot, (g >= 0) && (p.x <= 159) && (p.y <= 119));
            if (g >= 0) begin
                chk("vga_x", vga_x, p.x);
                chk("vga_y", vga_y, p.y);
                chk("vga_colour", vga_colour, p.c);
            end
            chk("arb_busy", busy, !all_fin());
            chk("arb_done", done, all_fin());
            cyc++;
        end
        req_valid = '0;
        chk("arb_drained", pending(), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        req_last   = '0;
        reset_model();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_plot_latency", vga_plot, 0);
        check_clear(-1);

        // Off-screen pixels, one in-range pixel, then a three-pixel run ending in last.
        q[0].push_back(mk(160, 5, 2, 0));
        q[0].push_back(mk(5, 120, 1, 0));
        q[0].push_back(mk(5, 5, 7, 0));
        q[0].push_back(mk(10, 20, 4, 0));
        q[0].push_back(mk(11, 20, 4, 0));
        q[0].push_back(mk(12, 20, 4, 1));
        run_arb(100, 1'b0, -1, 50);
        chk("req0_only_done", done, 0);
        chk("req0_only_busy", busy, 1);

        // req1 finishes with random gaps; finished req0 stays valid; start in ARB is ignored.
        for (int k = 0; k < 5; k++) q[1].push_back(rnd_pix(k == 4));
        run_arb(60, 1'b1, 2, 200);
        repeat (3) begin
            @(negedge clk);
            chk("done_hold", done, 1);
            chk("done_busy", busy, 0);
        end

        pulse_start();
        chk("restart_done_drop", done, 0);
        chk("restart_busy", busy, 1);
        reset_model();
        check_clear(5000);
        chk_zero("after_reset_release");

        pulse_start();
        check_clear(-1);

        order.delete();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) q[i].push_back(rnd_pix(k == 3));
        run_arb(100, 1'b0, -1, 100);
        chk("rr_order_len", order.size(), 8);
        for (int k = 0; k < order.size(); k++) chk("rr_order", order[k], k % 2);
        chk("rr_done", done, 1);
        chk("rr_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
